// File: rtl/dct_pkg.sv
// Shared constants and sample type for the DCT input stage, DCT core and quantizer.
package dct_pkg;

    localparam int unsigned PIX_WIDTH            = 8;
    localparam int unsigned DATA_IN_SIGNED_WIDTH = PIX_WIDTH + 1;
    localparam int unsigned LEVEL_SHIFT          = 1 << (PIX_WIDTH - 1);
    localparam int unsigned DCT_N                = 8;
    localparam int unsigned IDX_WIDTH            = $clog2(DCT_N);

    typedef logic signed [DATA_IN_SIGNED_WIDTH-1:0] dct_sample_t;

    // Unsigned pixel to signed sample centred on zero; the result always fits, so no saturation.
    function automatic dct_sample_t level_shift(input logic [PIX_WIDTH-1:0] pix);
        return dct_sample_t'({1'b0, pix}) - dct_sample_t'(LEVEL_SHIFT);
    endfunction

endpackage

// File: rtl/dct_row_loader_if.sv
// Pixel-in / row-out bundle of the DCT row loader.
interface dct_row_loader_if;
    import dct_pkg::*;

    logic                 pix_valid;
    logic [PIX_WIDTH-1:0] pix_in;
    logic                 pix_sol;
    logic                 pix_ready;

    dct_sample_t          data_out0;
    dct_sample_t          data_out1;
    dct_sample_t          data_out2;
    dct_sample_t          data_out3;
    dct_sample_t          data_out4;
    dct_sample_t          data_out5;
    dct_sample_t          data_out6;
    dct_sample_t          data_out7;
    logic                 vec_valid;
    logic                 vec_ready;
    logic                 row_err;

    // Pixel producer and row consumer side.
    modport master (
        output pix_valid, pix_in, pix_sol, vec_ready,
        input  pix_ready, vec_valid, row_err,
        input  data_out0, data_out1, data_out2, data_out3,
        input  data_out4, data_out5, data_out6, data_out7
    );

    // Loader side.
    modport slave (
        input  pix_valid, pix_in, pix_sol, vec_ready,
        output pix_ready, vec_valid, row_err,
        output data_out0, data_out1, data_out2, data_out3,
        output data_out4, data_out5, data_out6, data_out7
    );

endinterface

// File: rtl/dct_row_bank.sv
// One row of DCT_N samples: indexed write port, all entries readable in parallel.
module dct_row_bank
    import dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  dct_sample_t          wr_data,
    output dct_sample_t          rd_data [DCT_N]
);

    dct_sample_t mem_q [DCT_N];
    dct_sample_t mem_d [DCT_N];

    // Next contents: a single indexed write per cycle.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_data;
        end
    end

    // Sample storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DCT_N); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/dct_row_loader.sv
// Level-shifts a pixel stream and hands out complete rows of 8 signed samples from a ping-pong buffer.
module dct_row_loader
    import dct_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    dct_row_loader_if.slave   bus
);

    logic [1:0]           full_q,    full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [IDX_WIDTH-1:0] wr_idx_q,  wr_idx_d;
    logic                 row_err_q, row_err_d;

    logic                 pix_ready_c;
    logic                 vec_valid_c;
    logic                 pix_accept_c;
    logic                 row_take_c;
    logic                 sol_restart_c;
    logic [IDX_WIDTH-1:0] wr_ptr_c;
    dct_sample_t          wr_sample_c;

    dct_sample_t          bank0_rd [DCT_N];
    dct_sample_t          bank1_rd [DCT_N];
    dct_sample_t          data_sel [DCT_N];

    // Handshake decode; ready/valid are straight decodes of the full flags.
    always_comb begin
        pix_ready_c   = !full_q[wr_bank_q];
        vec_valid_c   = full_q[rd_bank_q];
        pix_accept_c  = bus.pix_valid && pix_ready_c;
        row_take_c    = vec_valid_c && bus.vec_ready;
        sol_restart_c = pix_accept_c && bus.pix_sol && (wr_idx_q != '0);
        wr_ptr_c      = sol_restart_c ? '0 : wr_idx_q;
        wr_sample_c   = level_shift(bus.pix_in);
    end

    // Pointer and flag update; take and completion always address different banks.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_idx_d  = wr_idx_q;
        row_err_d = sol_restart_c;

        if (row_take_c) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (pix_accept_c) begin
            if (sol_restart_c) begin
                // Restart the row: this pixel becomes sample 0, the partial row is dropped.
                wr_idx_d = IDX_WIDTH'(1);
            end else if (wr_idx_q == IDX_WIDTH'(DCT_N - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + IDX_WIDTH'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_idx_q  <= '0;
            row_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_idx_q  <= wr_idx_d;
            row_err_q <= row_err_d;
        end
    end

    dct_row_bank u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pix_accept_c && !wr_bank_q),
        .wr_idx  (wr_ptr_c),
        .wr_data (wr_sample_c),
        .rd_data (bank0_rd)
    );

    dct_row_bank u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (pix_accept_c && wr_bank_q),
        .wr_idx  (wr_ptr_c),
        .wr_data (wr_sample_c),
        .rd_data (bank1_rd)
    );

    // Read-bank select: register outputs through a mux, no arithmetic.
    always_comb begin
        for (int k = 0; k < int'(DCT_N); k++) begin
            data_sel[k] = rd_bank_q ? bank1_rd[k] : bank0_rd[k];
        end
    end

    assign bus.pix_ready = pix_ready_c;
    assign bus.vec_valid = vec_valid_c;
    assign bus.row_err   = row_err_q;
    assign bus.data_out0 = data_sel[0];
    assign bus.data_out1 = data_sel[1];
    assign bus.data_out2 = data_sel[2];
    assign bus.data_out3 = data_sel[3];
    assign bus.data_out4 = data_sel[4];
    assign bus.data_out5 = data_sel[5];
    assign bus.data_out6 = data_sel[6];
    assign bus.data_out7 = data_sel[7];

endmodule

// File: tb/tb_dct_row_loader.sv
// Directed and random bench for dct_row_loader against a row-queue reference model.
module tb_dct_row_loader;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dct_row_loader_if bus ();

    dct_row_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [8:0] lane [8];
    assign lane[0] = bus.data_out0;
    assign lane[1] = bus.data_out1;
    assign lane[2] = bus.data_out2;
    assign lane[3] = bus.data_out3;
    assign lane[4] = bus.data_out4;
    assign lane[5] = bus.data_out5;
    assign lane[6] = bus.data_out6;
    assign lane[7] = bus.data_out7;

    // Reference model: samples of the row being assembled, completed rows waiting (8 per row).
    int partial[$];
    int pend[$];
    bit exp_err;
    int hs_count;
    int err_count;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        partial.delete();
        pend.delete();
        exp_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pix_ready"}, bus.pix_ready, 1);
        chk({tag, "_vec_valid"}, bus.vec_valid, 0);
        chk({tag, "_row_err"},   bus.row_err,   0);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_lane%0d", tag, k), lane[k], 0);
    endtask

    // One clock: check outputs against the model, drive inputs, advance model and DUT.
    task automatic cycle(input bit v, input logic [7:0] p, input bit s, input bit vr);
        bit rdy;
        bit acc;
        bit take;
        bus.pix_valid = v;
        bus.pix_in    = p;
        bus.pix_sol   = s;
        bus.vec_ready = vr;
        #1;
        rdy = (pend.size() < 16);
        chk("pix_ready", bus.pix_ready, rdy);
        chk("vec_valid", bus.vec_valid, pend.size() > 0);
        chk("row_err",   bus.row_err,   exp_err);
        if (pend.size() > 0)
            for (int k = 0; k < 8; k++) chk($sformatf("lane%0d", k), lane[k], pend[k]);
        if (bus.vec_valid && vr) hs_count++;
        if (bus.row_err) err_count++;
        acc  = v && rdy;
        take = vr && (pend.size() > 0);
        exp_err = 1'b0;
        if (take) for (int k = 0; k < 8; k++) void'(pend.pop_front());
        if (acc) begin
            if (s && partial.size() > 0) begin
                partial.delete();
                exp_err = 1'b1;
            end
            partial.push_back(int'(p) - 128);
            if (partial.size() == 8) begin
                foreach (partial[i]) pend.push_back(partial[i]);
                partial.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset(input string tag);
        bus.pix_valid = 1'b0;
        bus.vec_ready = 1'b0;
        bus.pix_sol   = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] px [12];
        total = 0;
        bad   = 0;
        hs_count  = 0;
        err_count = 0;
        model_clear();
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.pix_sol   = 1'b0;
        bus.vec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp row taken immediately.
        for (int i = 0; i < 8; i++) cycle(1, 8'(i * 16), 0, 1);
        chk("ramp_vec_valid", bus.vec_valid, 1);
        chk("ramp_lane0", lane[0], -128);
        chk("ramp_lane7", lane[7], -16);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Fill both banks under back-pressure.
        for (int i = 0; i < 8; i++) cycle(1, 8'd255, 0, 0);
        for (int i = 0; i < 8; i++) cycle(1, 8'd0, 0, 0);
        chk("bp_pix_ready", bus.pix_ready, 0);
        chk("bp_lane3", lane[3], 127);
        cycle(1, 8'd77, 0, 0);
        cycle(0, 0, 0, 1);
        chk("bp_ready_back", bus.pix_ready, 1);
        chk("bp_row2_lane5", lane[5], -128);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);

        // Continuous stream of 8 rows.
        hs_count = 0;
        for (int i = 0; i < 64; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 1);
        cycle(0, 0, 0, 1);
        chk("stream_handshakes", hs_count, 8);
        cycle(0, 0, 0, 0);

        // Start-of-row on the 5th pixel drops the first four.
        err_count = 0;
        for (int i = 0; i < 12; i++) px[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 12; i++) cycle(1, px[i], i == 4, 0);
        chk("sol_lane0", lane[0], int'(px[4]) - 128);
        chk("sol_lane7", lane[7], int'(px[11]) - 128);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        chk("sol_err_pulses", err_count, 1);

        // Reset with one full row pending and three pixels in flight.
        for (int i = 0; i < 11; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 0);
        async_reset("midreset");
        hs_count  = 0;
        err_count = 0;
        for (int i = 0; i < 8; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("post_reset_rows", hs_count, 1);
        chk("post_reset_err", err_count, 0);

        // Random traffic with sparse start-of-row markers.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
